// File: rtl/mem_lsu_pkg.sv
// Shared constants and helpers for the MEM-stage load/store unit.
package mem_lsu_pkg;

  // funct3 access size / signedness
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // LSU state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Byte-strobe patterns before lane shifting
  localparam logic [3:0] WSTRB_B = 4'b0001;
  localparam logic [3:0] WSTRB_H = 4'b0011;
  localparam logic [3:0] WSTRB_W = 4'b1111;

  // True when the access has a legal funct3 for its direction and is naturally aligned.
  function automatic logic access_ok(input logic is_load, input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic legal_f3;
    logic misaligned;
    if (is_load)
      legal_f3 = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
    else
      legal_f3 = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    misaligned = ((f3[1:0] == 2'b01) && lo[0]) ||
                 ((f3[1:0] == 2'b10) && (lo != 2'b00));
    return legal_f3 && !misaligned;
  endfunction

  // Replicates store data so the addressed lane carries the value.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Byte strobes for a store, shifted to the addressed lane.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] r;
    case (f3[1:0])
      2'b00:   r = 4'(WSTRB_B << lo);
      2'b01:   r = 4'(WSTRB_H << lo);
      default: r = WSTRB_W;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a read word and extends it to 32 bits.
module lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane selection followed by sign or zero extension.
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_v[7]}}, byte_v};
      F3_BU:   result = {24'h0, byte_v};
      F3_H:    result = {{16{half_v[15]}}, half_v};
      F3_HU:   result = {16'h0, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store requests into a
// req/gnt/rvalid data-memory transaction and presents results to MEM/WB.
//
// Bus handshake: dmem_req is held high with stable addr/we/wdata/wstrb until
// the cycle dmem_gnt is seen high; that cycle accepts the request. Exactly one
// dmem_rvalid pulse (loads and stores alike) completes it, either in the grant
// cycle or any later cycle. An rvalid with no accepted request outstanding is
// ignored.
module mem_stage_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic        wb_reg_file_in,
  input  logic        memtoreg_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] alu_result_out,
  output logic [31:0] load_data_out,
  output logic [4:0]  rd_out,
  output logic        wb_reg_file_out,
  output logic        memtoreg_out,
  output logic        stall_out,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [1:0]  state_dbg
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]  state_q;
  logic [7:0]  cnt_q;
  logic [31:0] alu_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        we_q;
  logic [4:0]  rd_q;
  logic        wb_q;
  logic        mtr_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [31:0] ld_data_q;

  logic        mem_op;
  logic        op_ok;
  logic        timeout_hit;
  logic [31:0] aligned_data;

  assign mem_op      = mem_read_in | mem_write_in;
  // Read wins when both flags are set, so the direction is just mem_read_in.
  assign op_ok       = access_ok(mem_read_in, funct3_in, alu_result_in[1:0]);
  assign timeout_hit = (state_q == ST_WAIT) && !dmem_rvalid && (cnt_q == TMO_LAST);
  assign state_dbg   = state_q;

  lsu_load_align u_align (
    .rdata   (dmem_rdata),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .result  (aligned_data)
  );

  // FSM and holding registers: capture in IDLE, hold through the bus access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      alu_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      mtr_q     <= 1'b0;
      f3_q      <= '0;
      lo_q      <= '0;
      ld_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_op && op_ok) begin
            state_q   <= ST_REQ;
            cnt_q     <= '0;
            alu_q     <= alu_result_in;
            addr_q    <= {alu_result_in[31:2], 2'b00};
            lo_q      <= alu_result_in[1:0];
            f3_q      <= funct3_in;
            rd_q      <= rd_in;
            wb_q      <= wb_reg_file_in;
            mtr_q     <= memtoreg_in;
            we_q      <= ~mem_read_in;
            ld_data_q <= '0;
            if (mem_read_in) begin
              wdata_q <= '0;
              wstrb_q <= '0;
            end else begin
              wdata_q <= store_lanes(funct3_in, store_data_in);
              wstrb_q <= store_strb(funct3_in, alu_result_in[1:0]);
            end
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            cnt_q <= '0;
            if (dmem_rvalid) begin
              ld_data_q <= we_q ? 32'h0 : aligned_data;
              state_q   <= ST_DONE;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            ld_data_q <= we_q ? 32'h0 : aligned_data;
            state_q   <= ST_DONE;
          end else if (timeout_hit) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pipeline-facing outputs: pass-through, bubble, or the completed access.
  always_comb begin
    alu_result_out  = '0;
    load_data_out   = '0;
    rd_out          = '0;
    wb_reg_file_out = 1'b0;
    memtoreg_out    = 1'b0;
    stall_out       = 1'b0;
    misalign_err    = 1'b0;
    bus_err         = 1'b0;
    dmem_req        = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (!mem_op) begin
            alu_result_out  = alu_result_in;
            rd_out          = rd_in;
            wb_reg_file_out = wb_reg_file_in;
            memtoreg_out    = memtoreg_in;
          end else if (!op_ok) begin
            misalign_err = 1'b1;
          end else begin
            stall_out = 1'b1;
          end
        end
        ST_REQ: begin
          dmem_req  = 1'b1;
          stall_out = 1'b1;
        end
        ST_WAIT: begin
          if (timeout_hit) bus_err = 1'b1;
          else             stall_out = 1'b1;
        end
        ST_DONE: begin
          alu_result_out  = alu_q;
          load_data_out   = ld_data_q;
          rd_out          = rd_q;
          wb_reg_file_out = wb_q & ~we_q;
          memtoreg_out    = mtr_q;
        end
        default: ;
      endcase
    end
  end

  // Bus attributes come straight from the captured registers so they stay stable.
  always_comb begin
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_wstrb = '0;
    if (!rst) begin
      dmem_we    = we_q;
      dmem_addr  = addr_q;
      dmem_wdata = wdata_q;
      dmem_wstrb = wstrb_q;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised and directed bench for mem_stage_lsu with a cycle-level reference model.
module tb_mem_stage_lsu;
  import mem_lsu_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_result_in = '0;
  logic [31:0] store_data_in = '0;
  logic [4:0]  rd_in = '0;
  logic        wb_reg_file_in = 1'b0;
  logic        memtoreg_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [2:0]  funct3_in = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] alu_result_out;
  logic [31:0] load_data_out;
  logic [4:0]  rd_out;
  logic        wb_reg_file_out;
  logic        memtoreg_out;
  logic        stall_out;
  logic        misalign_err;
  logic        bus_err;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_lsu #(.TIMEOUT_CYC(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_result_in   (alu_result_in),
    .store_data_in   (store_data_in),
    .rd_in           (rd_in),
    .wb_reg_file_in  (wb_reg_file_in),
    .memtoreg_in     (memtoreg_in),
    .mem_read_in     (mem_read_in),
    .mem_write_in    (mem_write_in),
    .funct3_in       (funct3_in),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_wstrb      (dmem_wstrb),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .alu_result_out  (alu_result_out),
    .load_data_out   (load_data_out),
    .rd_out          (rd_out),
    .wb_reg_file_out (wb_reg_file_out),
    .memtoreg_out    (memtoreg_out),
    .stall_out       (stall_out),
    .misalign_err    (misalign_err),
    .bus_err         (bus_err),
    .state_dbg       (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_legal(input bit is_load, input int f3, input int lo);
    bit ok_f3;
    if (is_load) ok_f3 = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else         ok_f3 = (f3 == 0) || (f3 == 1) || (f3 == 2);
    if (!ok_f3) return 0;
    if ((f3 % 4) == 1 && (lo % 2) != 0) return 0;
    if ((f3 % 4) == 2 && lo != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input int lo, input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * lo)) & 32'hFF;
    h = (word >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
      4: return b;
      1: return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
      5: return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] d);
    if (f3 == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_wstrb(input int f3, input int lo);
    if (f3 == 0) return 32'(1 << lo);
    if (f3 == 1) return 32'(3 << lo);
    return 32'hF;
  endfunction

  task automatic bus_idle();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = $urandom;
  endtask

  // Drives one instruction, plays the memory side (gnt after g extra REQ cycles,
  // rvalid r cycles after gnt, or never when tmo) and checks every cycle.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] rdv,
                        input logic wbv, input logic mtrv, input logic rdn, input logic wrn,
                        input logic [2:0] f3, input logic [31:0] word,
                        input int g, input int r, input bit tmo);
    bit is_mem;
    bit is_load;
    bit legal;
    int lo;
    lo      = int'(alu[1:0]);
    is_mem  = rdn || wrn;
    is_load = rdn;
    legal   = ref_legal(is_load, int'(f3), lo);
    @(posedge clk); #1;
    alu_result_in = alu; store_data_in = sdata; rd_in = rdv; wb_reg_file_in = wbv;
    memtoreg_in = mtrv; mem_read_in = rdn; mem_write_in = wrn; funct3_in = f3;
    bus_idle();
    @(negedge clk);
    if (!is_mem) begin
      check("pass_alu", alu_result_out, alu);
      check("pass_rd", rd_out, rdv);
      check("pass_wb", wb_reg_file_out, wbv);
      check("pass_mtr", memtoreg_out, mtrv);
      check("pass_ld", load_data_out, 0);
      check("pass_stall", stall_out, 0);
      check("pass_req", dmem_req, 0);
      return;
    end
    if (!legal) begin
      check("mis_err", misalign_err, 1);
      check("mis_req", dmem_req, 0);
      check("mis_stall", stall_out, 0);
      check("mis_wb", wb_reg_file_out, 0);
      check("mis_rd", rd_out, 0);
      return;
    end
    check("cap_stall", stall_out, 1);
    check("cap_req", dmem_req, 0);
    check("cap_wb", wb_reg_file_out, 0);
    check("cap_rd", rd_out, 0);
    check("cap_mis", misalign_err, 0);
    for (int k = 0; k <= g; k++) begin
      @(posedge clk); #1; bus_idle();
      @(negedge clk);
      check("req_req", dmem_req, 1);
      check("req_stall", stall_out, 1);
      check("req_wb", wb_reg_file_out, 0);
      check("req_addr", dmem_addr, alu & 32'hFFFF_FFFC);
      check("req_we", dmem_we, !is_load);
      if (!is_load) begin
        check("req_wdata", dmem_wdata, ref_wdata(int'(f3), sdata));
        check("req_wstrb", dmem_wstrb, ref_wstrb(int'(f3), lo));
      end
      if (k == g) begin
        dmem_gnt = 1'b1;
        if (r == 0 && !tmo) begin dmem_rvalid = 1'b1; dmem_rdata = word; end
      end
    end
    if (tmo) begin
      for (int k = 1; k <= TMO; k++) begin
        @(posedge clk); #1; bus_idle();
        @(negedge clk);
        check("tmo_req", dmem_req, 0);
        check("tmo_wb", wb_reg_file_out, 0);
        check("tmo_rd", rd_out, 0);
        check("tmo_berr", bus_err, (k == TMO));
        check("tmo_stall", stall_out, (k != TMO));
      end
      return;
    end
    for (int k = 1; k <= r; k++) begin
      @(posedge clk); #1; bus_idle();
      @(negedge clk);
      check("wait_req", dmem_req, 0);
      check("wait_stall", stall_out, 1);
      check("wait_berr", bus_err, 0);
      check("wait_wb", wb_reg_file_out, 0);
      if (k == r) begin dmem_rvalid = 1'b1; dmem_rdata = word; end
    end
    @(posedge clk); #1; bus_idle();
    @(negedge clk);
    check("done_stall", stall_out, 0);
    check("done_req", dmem_req, 0);
    check("done_alu", alu_result_out, alu);
    check("done_rd", rd_out, rdv);
    check("done_wb", wb_reg_file_out, wbv && is_load);
    check("done_mtr", memtoreg_out, mtrv);
    check("done_ld", load_data_out, is_load ? ref_load(int'(f3), lo, word) : 32'h0);
  endtask

  initial begin
    // Reset: outputs forced to zero even with a pass-through op on the inputs.
    alu_result_in = 32'hDEAD_BEEF; rd_in = 5'd7; wb_reg_file_in = 1'b1;
    #12;
    check("rst_alu", alu_result_out, 0);
    check("rst_wb", wb_reg_file_out, 0);
    check("rst_stall", stall_out, 0);
    check("rst_req", dmem_req, 0);
    check("rst_state", state_dbg, ST_IDLE);
    @(negedge clk); rst = 1'b0;

    // Directed cases
    run_op(32'h1234, 0, 5'd5, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    run_op(32'h1003, 0, 5'd9, 1, 1, 1, 0, F3_B, 32'h80FF_0000, 0, 1, 0);
    run_op(32'h1003, 0, 5'd9, 1, 1, 1, 0, F3_BU, 32'h80FF_0000, 0, 1, 0);
    run_op(32'h2002, 32'h0000_ABCD, 5'd3, 1, 0, 0, 1, F3_H, 0, 0, 1, 0);
    run_op(32'h3001, 0, 5'd4, 1, 1, 1, 0, F3_W, 0, 0, 0, 0);
    run_op(32'h3008, 0, 5'd6, 1, 1, 1, 0, F3_W, 32'h1111_2222, 0, 0, 1);

    // A late rvalid after the timeout must not disturb an IDLE pass-through.
    @(posedge clk); #1;
    mem_read_in = 0; mem_write_in = 0; alu_result_in = 32'h55; rd_in = 5'd2; wb_reg_file_in = 1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("late_alu", alu_result_out, 32'h55);
    check("late_stall", stall_out, 0);
    @(posedge clk); #1; bus_idle();
    @(negedge clk);
    check("late_state", state_dbg, ST_IDLE);
    check("late_req", dmem_req, 0);

    // Reset asserted in WAIT
    @(posedge clk); #1;
    alu_result_in = 32'h5000; mem_read_in = 1; funct3_in = F3_W; rd_in = 5'd8; wb_reg_file_in = 1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk); dmem_gnt = 1'b1;
    @(posedge clk); #1; bus_idle();
    @(negedge clk);
    check("rw_stall", stall_out, 1);
    check("rw_req", dmem_req, 0);
    #2 rst = 1'b1;
    #1;
    check("rw_rst_req", dmem_req, 0);
    check("rw_rst_stall", stall_out, 0);
    check("rw_rst_alu", alu_result_out, 0);
    check("rw_rst_wb", wb_reg_file_out, 0);
    check("rw_rst_state", state_dbg, ST_IDLE);
    @(negedge clk); rst = 1'b0; mem_read_in = 0;
    run_op(32'h4000, 0, 5'd10, 1, 1, 1, 0, F3_W, 32'hCAFE_F00D, 1, 2, 0);

    // Randomised mix
    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 4);
      f3   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = {f3[2] & f3[0], f3[1] & ~f3[0], f3[0]};
      run_op($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             (kind == 1 || kind == 2 || kind == 4), (kind == 3 || kind == 4), f3,
             $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
